ram_soc_banked: RTL and testbench

- Parametrised successor to the fixed four-chip RAM SoC.
- NUM_CH independent channels share one global address space striped across NUM_BANKS dual-port banks (one write port, one read port per bank).
- Each bank has round-robin arbitration with a ready handshake that stalls losing channels.
- Sits between the channel masters (test harness or bus adapters) and on-chip storage.

---
 rtl/ram_soc_banked_if.sv | 27 ++
 rtl/ram_soc_banked.sv | 143 ++++++++++++++
 tb/tb_ram_soc_banked.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_soc_banked_if.sv
// Channel-side bundle for ram_soc_banked: per-channel write and read request
// buses with their grants and read-return path, packed channel i at slice i.
interface ram_soc_banked_if #(
   parameter int NUM_CH = 4,
   parameter int DATA_W = 64,
   parameter int ADDR_W = 12
) ();
   logic [NUM_CH-1:0]        ch_write;
   logic [NUM_CH*ADDR_W-1:0] ch_wr_address;
   logic [NUM_CH*DATA_W-1:0] ch_data_in;
   logic [NUM_CH-1:0]        ch_wr_ready;
   logic [NUM_CH-1:0]        ch_read;
   logic [NUM_CH*ADDR_W-1:0] ch_rd_address;
   logic [NUM_CH-1:0]        ch_rd_ready;
   logic [NUM_CH*DATA_W-1:0] ch_data_out;
   logic [NUM_CH-1:0]        ch_rd_valid;

   modport master (
      output ch_write, ch_wr_address, ch_data_in, ch_read, ch_rd_address,
      input  ch_wr_ready, ch_rd_ready, ch_data_out, ch_rd_valid
   );

   modport slave (
      input  ch_write, ch_wr_address, ch_data_in, ch_read, ch_rd_address,
      output ch_wr_ready, ch_rd_ready, ch_data_out, ch_rd_valid
   );
endinterface

// File: rtl/ram_soc_banked.sv
// Multi-channel banked RAM: global word space striped over NUM_BANKS dual-port
// banks, each with independent round-robin write and read arbiters.
module ram_soc_banked #(
   parameter int NUM_CH    = 4,
   parameter int NUM_BANKS = 4,
   parameter int DATA_W    = 64,
   parameter int ADDR_W    = 12
) (
   input  logic           clock,
   input  logic           resetn,
   ram_soc_banked_if.slave bus
);
   localparam int BS    = $clog2(NUM_BANKS);
   localparam int BK_W  = (BS > 0) ? BS : 1;
   localparam int ROW_W = ADDR_W - BS;
   localparam int DEPTH = 1 << ROW_W;
   localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   // Handshake: a transfer completes on a cycle where request and ready are
   // both high. Ready is combinational from requests and pointers, never high
   // without its request, and forced low during reset; a stalled channel must
   // hold request, address and data until it sees ready.

   logic [ADDR_W-1:0] wa [NUM_CH];
   logic [ADDR_W-1:0] ra [NUM_CH];
   logic [DATA_W-1:0] wd [NUM_CH];
   logic [DATA_W-1:0] rd_data_q [NUM_CH];
   logic [NUM_CH-1:0] rd_valid_q;

   genvar g;
   generate
      for (g = 0; g < NUM_CH; g++) begin : g_ch
         assign wa[g] = bus.ch_wr_address[g*ADDR_W +: ADDR_W];
         assign ra[g] = bus.ch_rd_address[g*ADDR_W +: ADDR_W];
         assign wd[g] = bus.ch_data_in[g*DATA_W +: DATA_W];
         assign bus.ch_data_out[g*DATA_W +: DATA_W] = rd_data_q[g];
      end
   endgenerate

   function automatic logic [BK_W-1:0] bank_of(input logic [ADDR_W-1:0] a);
      logic [ADDR_W-1:0] mask;
      mask = ADDR_W'(NUM_BANKS - 1);
      return BK_W'(a & mask);
   endfunction

   function automatic logic [ROW_W-1:0] row_of(input logic [ADDR_W-1:0] a);
      return ROW_W'(a >> BS);
   endfunction

   // Returns {found, winner}: first candidate at or after ptr, wrapping round.
   function automatic logic [CH_W:0] pick(input logic [NUM_CH-1:0] cand,
                                          input logic [CH_W-1:0]   ptr);
      logic            found;
      logic [CH_W-1:0] idx;
      found = 1'b0;
      idx   = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (!found && cand[c] && c >= int'(ptr)) begin
            found = 1'b1;
            idx   = CH_W'(c);
         end
      end
      for (int c = 0; c < NUM_CH; c++) begin
         if (!found && cand[c] && c < int'(ptr)) begin
            found = 1'b1;
            idx   = CH_W'(c);
         end
      end
      return {found, idx};
   endfunction

   function automatic logic [CH_W-1:0] next_ptr(input logic [CH_W-1:0] w);
      return (int'(w) == NUM_CH - 1) ? '0 : w + CH_W'(1);
   endfunction

   logic [CH_W-1:0]      wr_ptr [NUM_BANKS];
   logic [CH_W-1:0]      rd_ptr [NUM_BANKS];
   logic [CH_W-1:0]      wr_win [NUM_BANKS];
   logic [CH_W-1:0]      rd_win [NUM_BANKS];
   logic [NUM_BANKS-1:0] wr_any;
   logic [NUM_BANKS-1:0] rd_any;
   logic [NUM_CH-1:0]    wr_gnt;
   logic [NUM_CH-1:0]    rd_gnt;

   always_comb begin
      logic [NUM_CH-1:0] wc;
      logic [NUM_CH-1:0] rc;
      wr_gnt = '0;
      rd_gnt = '0;
      wc     = '0;
      rc     = '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         for (int c = 0; c < NUM_CH; c++) begin
            wc[c] = bus.ch_write[c] && (bank_of(wa[c]) == BK_W'(b));
            rc[c] = bus.ch_read[c]  && (bank_of(ra[c]) == BK_W'(b));
         end
         {wr_any[b], wr_win[b]} = pick(wc, wr_ptr[b]);
         {rd_any[b], rd_win[b]} = pick(rc, rd_ptr[b]);
         if (wr_any[b]) wr_gnt[wr_win[b]] = 1'b1;
         if (rd_any[b]) rd_gnt[rd_win[b]] = 1'b1;
      end
   end

   assign bus.ch_wr_ready = wr_gnt & {NUM_CH{resetn}};
   assign bus.ch_rd_ready = rd_gnt & {NUM_CH{resetn}};
   assign bus.ch_rd_valid = rd_valid_q;

   always_ff @(posedge clock) begin
      if (!resetn) begin
         for (int b = 0; b < NUM_BANKS; b++) begin
            wr_ptr[b] <= '0;
            rd_ptr[b] <= '0;
         end
      end else begin
         for (int b = 0; b < NUM_BANKS; b++) begin
            if (wr_any[b]) wr_ptr[b] <= next_ptr(wr_win[b]);
            if (rd_any[b]) rd_ptr[b] <= next_ptr(rd_win[b]);
         end
      end
   end

   // Storage is not reset; writes granted on a reset edge are dropped.
   logic [DATA_W-1:0] mem [NUM_BANKS][DEPTH];

   always_ff @(posedge clock) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
         if (resetn && wr_any[b]) mem[b][row_of(wa[wr_win[b]])] <= wd[wr_win[b]];
      end
   end

   // Reads sample the array before this edge's writes land: read-before-write.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         rd_valid_q <= '0;
         for (int c = 0; c < NUM_CH; c++) rd_data_q[c] <= '0;
      end else begin
         rd_valid_q <= rd_gnt;
         for (int c = 0; c < NUM_CH; c++) begin
            if (rd_gnt[c]) rd_data_q[c] <= mem[bank_of(ra[c])][row_of(ra[c])];
         end
      end
   end
endmodule

// File: tb/tb_ram_soc_banked.sv
// Bench for ram_soc_banked: directed scenarios plus random traffic checked
// against a flat-memory round-robin reference model through per-channel queues.
module tb_ram_soc_banked;
   localparam int NC = 4;
   localparam int NB = 4;
   localparam int DW = 64;
   localparam int AW = 12;

   // clock / reset
   logic clock  = 1'b0;
   logic resetn = 1'b0;
   always #5 clock = ~clock;

   ram_soc_banked_if #(.NUM_CH(NC), .DATA_W(DW), .ADDR_W(AW)) bus ();

   ram_soc_banked #(.NUM_CH(NC), .NUM_BANKS(NB), .DATA_W(DW), .ADDR_W(AW)) dut (
      .clock  (clock),
      .resetn (resetn),
      .bus    (bus)
   );

   // stimulus state
   logic          rw [NC];
   logic          rr [NC];
   logic [AW-1:0] wa [NC];
   logic [AW-1:0] ra [NC];
   logic [DW-1:0] wd [NC];

   // reference model state
   logic [DW-1:0] mem_m [1<<AW];
   int            wptr [NB];
   int            rptr [NB];
   logic [DW-1:0] exp_q [NC][$];
   logic [DW-1:0] hold_exp [NC];
   logic [NC-1:0] last_wg;
   logic [NC-1:0] last_rg;

   int checks = 0;
   int passes = 0;

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // driver tasks
   task automatic apply();
      for (int c = 0; c < NC; c++) begin
         bus.ch_write[c]                  = rw[c];
         bus.ch_read[c]                   = rr[c];
         bus.ch_wr_address[c*AW +: AW]    = wa[c];
         bus.ch_rd_address[c*AW +: AW]    = ra[c];
         bus.ch_data_in[c*DW +: DW]       = wd[c];
      end
   endtask

   task automatic idle_all();
      for (int c = 0; c < NC; c++) begin
         rw[c] = 1'b0;
         rr[c] = 1'b0;
      end
      apply();
   endtask

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic sample();
      @(negedge clock);
      #2;
   endtask

   // Reference model: grants from the round-robin rule, reads see memory as it
   // was before this cycle's writes, effects commit at the edge unless reset.
   initial begin : model
      logic [NC-1:0] eg_w;
      logic [NC-1:0] eg_r;
      logic          pv [NB];
      logic [AW-1:0] pa [NB];
      logic [DW-1:0] pd [NB];
      int            nwp [NB];
      int            nrp [NB];
      logic          rfound;
      int            c;
      forever begin
         @(negedge clock);
         #1;
         eg_w = '0;
         eg_r = '0;
         for (int b = 0; b < NB; b++) begin
            pv[b]  = 1'b0;
            pa[b]  = '0;
            pd[b]  = '0;
            nwp[b] = wptr[b];
            nrp[b] = rptr[b];
            rfound = 1'b0;
            if (resetn) begin
               for (int k = 0; k < NC; k++) begin
                  c = (wptr[b] + k) % NC;
                  if (!pv[b] && rw[c] && (int'(wa[c]) % NB) == b) begin
                     pv[b] = 1'b1; pa[b] = wa[c]; pd[b] = wd[c];
                     eg_w[c] = 1'b1; nwp[b] = (c + 1) % NC;
                  end
                  c = (rptr[b] + k) % NC;
                  if (!rfound && rr[c] && (int'(ra[c]) % NB) == b) begin
                     rfound = 1'b1;
                     eg_r[c] = 1'b1; nrp[b] = (c + 1) % NC;
                     exp_q[c].push_back(mem_m[ra[c]]);
                  end
               end
            end
         end
         check("wr_ready", DW'(bus.ch_wr_ready), DW'(eg_w));
         check("rd_ready", DW'(bus.ch_rd_ready), DW'(eg_r));
         last_wg = eg_w;
         last_rg = eg_r;
         @(posedge clock);
         if (!resetn) begin
            for (int i = 0; i < NC; i++) begin
               exp_q[i].delete();
               hold_exp[i] = '0;
            end
            for (int b = 0; b < NB; b++) begin
               wptr[b] = 0;
               rptr[b] = 0;
            end
         end else begin
            for (int b = 0; b < NB; b++) begin
               if (pv[b]) mem_m[pa[b]] = pd[b];
               wptr[b] = nwp[b];
               rptr[b] = nrp[b];
            end
         end
      end
   end

   // scoreboard monitor
   initial begin : monitor
      logic exp_v;
      forever begin
         @(negedge clock);
         for (int c = 0; c < NC; c++) begin
            exp_v = (exp_q[c].size() > 0);
            check($sformatf("rd_valid[%0d]", c), DW'(bus.ch_rd_valid[c]), DW'(exp_v));
            if (exp_v) hold_exp[c] = exp_q[c].pop_front();
            check($sformatf("data_out[%0d]", c), bus.ch_data_out[c*DW +: DW], hold_exp[c]);
         end
      end
   end

   initial begin : main
      logic [NC-1:0] order [5];
      logic [DW-1:0] val_a;
      logic [DW-1:0] val_b;
      order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100;
      order[3] = 4'b1000; order[4] = 4'b0001;
      for (int b = 0; b < NB; b++) begin
         wptr[b] = 0;
         rptr[b] = 0;
      end
      for (int c = 0; c < NC; c++) begin
         hold_exp[c] = '0;
         rw[c] = 1'b1; rr[c] = 1'b0;
         wa[c] = AW'(c); ra[c] = '0; wd[c] = '0;
      end
      apply();

      // reset with all writes requesting
      repeat (3) cyc();
      sample();
      check("reset_wr_ready", DW'(bus.ch_wr_ready), '0);
      check("reset_rd_valid", DW'(bus.ch_rd_valid), '0);
      cyc();
      resetn = 1'b1;
      idle_all();
      repeat (2) cyc();

      // bank 2 conflict: everyone writes continuously
      for (int c = 0; c < NC; c++) begin
         rw[c] = 1'b1;
         wa[c] = AW'(2 + 4*c);
         wd[c] = {$urandom, $urandom};
      end
      apply();
      for (int i = 0; i < 5; i++) begin
         sample();
         check($sformatf("rr_order%0d", i), DW'(bus.ch_wr_ready), DW'(order[i]));
         cyc();
      end
      idle_all();
      cyc();

      // fill addresses 0..31, one bank per channel so all grant in parallel
      for (int k = 0; k < 8; k++) begin
         for (int c = 0; c < NC; c++) begin
            rw[c] = 1'b1;
            wa[c] = AW'(4*k + c);
            wd[c] = {$urandom, $urandom};
         end
         apply();
         cyc();
      end
      idle_all();
      cyc();

      // single write then read from another channel
      rw[0] = 1'b1; wa[0] = 12'h005; wd[0] = 64'hDEAD_BEEF_0000_0001;
      apply();
      sample();
      check("single_wr_ready", DW'(bus.ch_wr_ready[0]), DW'(1'b1));
      cyc();
      rw[0] = 1'b0; rr[2] = 1'b1; ra[2] = 12'h005;
      apply();
      sample();
      check("single_rd_ready", DW'(bus.ch_rd_ready[2]), DW'(1'b1));
      cyc();
      idle_all();
      sample();
      check("single_valid", DW'(bus.ch_rd_valid[2]), DW'(1'b1));
      check("single_data", bus.ch_data_out[2*DW +: DW], 64'hDEAD_BEEF_0000_0001);
      cyc();

      // parallel reads across all banks
      for (int c = 0; c < NC; c++) begin
         rr[c] = 1'b1;
         ra[c] = AW'(c);
      end
      apply();
      sample();
      check("par_rd_ready", DW'(bus.ch_rd_ready), DW'(4'hF));
      cyc();
      idle_all();
      sample();
      check("par_rd_valid", DW'(bus.ch_rd_valid), DW'(4'hF));
      cyc();

      // same-cycle write and read to one address
      val_a = 64'h0123_4567_89AB_CDEF;
      val_b = 64'hFEDC_BA98_7654_3210;
      rw[1] = 1'b1; wa[1] = 12'h010; wd[1] = val_a;
      apply();
      cyc();
      wd[1] = val_b; rr[3] = 1'b1; ra[3] = 12'h010;
      apply();
      cyc();
      rw[1] = 1'b0;
      apply();
      sample();
      check("collide_old", bus.ch_data_out[3*DW +: DW], val_a);
      cyc();
      idle_all();
      sample();
      check("collide_new", bus.ch_data_out[3*DW +: DW], val_b);
      cyc();

      // reset landing on the edge that ends a read grant
      rr[0] = 1'b1; ra[0] = 12'h005;
      apply();
      sample();
      check("midrst_rd_ready", DW'(bus.ch_rd_ready[0]), DW'(1'b1));
      resetn = 1'b0;
      idle_all();
      cyc();
      sample();
      check("midrst_rd_valid", DW'(bus.ch_rd_valid), '0);
      check("midrst_data", bus.ch_data_out[0 +: DW], '0);
      cyc();
      resetn = 1'b1;
      rr[1] = 1'b1; ra[1] = 12'h005;
      apply();
      cyc();
      idle_all();
      sample();
      check("post_rst_data", bus.ch_data_out[1*DW +: DW], 64'hDEAD_BEEF_0000_0001);
      cyc();

      // random traffic; stalled requests are held until granted
      for (int n = 0; n < 2000; n++) begin
         for (int c = 0; c < NC; c++) begin
            if (!rw[c] || last_wg[c]) begin
               rw[c] = ($urandom_range(0, 99) < 60);
               wa[c] = AW'($urandom_range(0, 31));
               wd[c] = {$urandom, $urandom};
            end
            if (!rr[c] || last_rg[c]) begin
               rr[c] = ($urandom_range(0, 99) < 60);
               ra[c] = AW'($urandom_range(0, 31));
            end
         end
         apply();
         cyc();
      end
      idle_all();
      repeat (3) cyc();

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
